riscv_div_unit: RTL

- Sequential front/back end for the combinational unsigned divider core `RiscVFastDiv`.
- Accepts RV32M DIV/DIVU/REM/REMU requests over a valid/ready handshake and registers the operands.
- Converts signed operands to magnitudes and holds them on the core for a fixed multicycle settle window.
- Resolves the divide-by-zero and signed-overflow cases, restores signs, and presents the registered result to the writeback stage.

---
 rtl/riscv_div_unit.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/riscv_div_unit.sv
// RV32M DIV/DIVU/REM/REMU unit: handshake front end, sign handling and special cases
// around a combinational unsigned divider core held stable for a fixed settle window.

module riscv_div_unit #(
  parameter int unsigned DIV_CYCLES = 2,
  parameter int unsigned TAG_W      = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [1:0]       in_op_i,
  input  logic [31:0]      in_a_i,
  input  logic [31:0]      in_b_i,
  input  logic [TAG_W-1:0] in_tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [31:0]      out_result_o,
  output logic [TAG_W-1:0] out_tag_o
);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic               sign_q_q, sign_q_d;
  logic               sign_r_q, sign_r_d;
  logic [31:0]        abs_a_q, abs_a_d;
  logic [31:0]        abs_b_q, abs_b_d;
  logic [31:0]        result_q, result_d;

  logic               in_signed;
  logic               b_zero;
  logic               sgn_ovf;
  logic [31:0]        core_q, core_r;
  logic [31:0]        calc_result;

  assign in_signed = ~in_op_i[0];
  assign b_zero    = (in_b_i == 32'h0);
  assign sgn_ovf   = in_signed && (in_a_i == 32'h8000_0000) && (in_b_i == 32'hFFFF_FFFF);

  // Core sees only registered magnitudes, stable for the whole calc window.
  RiscVFastDiv u_core (
    .x_i (abs_a_q),
    .y_i (abs_b_q),
    .q_o (core_q),
    .r_o (core_r)
  );

  always_comb begin
    if (op_q[1]) begin
      calc_result = sign_r_q ? (32'h0 - core_r) : core_r;
    end else begin
      calc_result = sign_q_q ? (32'h0 - core_q) : core_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    tag_d    = tag_q;
    sign_q_d = sign_q_q;
    sign_r_d = sign_r_q;
    abs_a_d  = abs_a_q;
    abs_b_d  = abs_b_q;
    result_d = result_q;

    if (flush_i) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid_i) begin
            op_d     = in_op_i;
            tag_d    = in_tag_i;
            sign_q_d = in_signed && (in_a_i[31] ^ in_b_i[31]) && !b_zero;
            sign_r_d = in_signed && in_a_i[31];
            abs_a_d  = (in_signed && in_a_i[31]) ? (32'h0 - in_a_i) : in_a_i;
            abs_b_d  = (in_signed && in_b_i[31]) ? (32'h0 - in_b_i) : in_b_i;
            if (b_zero) begin
              result_d = in_op_i[1] ? in_a_i : 32'hFFFF_FFFF;
              state_d  = StDone;
            end else if (sgn_ovf) begin
              result_d = in_op_i[1] ? 32'h0 : 32'h8000_0000;
              state_d  = StDone;
            end else begin
              cnt_d   = 4'(DIV_CYCLES - 1);
              state_d = StCalc;
            end
          end
        end
        StCalc: begin
          if (cnt_q == 4'd0) begin
            result_d = calc_result;
            state_d  = StDone;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        StDone: begin
          if (out_ready_i) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      op_q     <= 2'b00;
      tag_q    <= '0;
      sign_q_q <= 1'b0;
      sign_r_q <= 1'b0;
      abs_a_q  <= 32'h0;
      abs_b_q  <= 32'h0;
      result_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      tag_q    <= tag_d;
      sign_q_q <= sign_q_d;
      sign_r_q <= sign_r_d;
      abs_a_q  <= abs_a_d;
      abs_b_q  <= abs_b_d;
      result_q <= result_d;
    end
  end

  assign in_ready_o   = (state_q == StIdle);
  assign out_valid_o  = (state_q == StDone);
  assign out_result_o = result_q;
  assign out_tag_o    = tag_q;

endmodule

// Combinational unsigned divider on 32-bit magnitudes.
module RiscVFastDiv (
  input  logic [31:0] x_i,
  input  logic [31:0] y_i,
  output logic [31:0] q_o,
  output logic [31:0] r_o
);

  // y_i is never zero while a result is sampled; the guard only keeps idle values defined.
  assign q_o = (y_i == 32'h0) ? 32'hFFFF_FFFF : (x_i / y_i);
  assign r_o = (y_i == 32'h0) ? x_i : (x_i % y_i);

endmodule
